// File: rtl/wts_channel_scheduler.sv
// wts_channel_scheduler
//   Time-division sequencer for the shared 5-channel ADSR envelope datapath.
//   A slot counter walks 0..PERIOD-1. Slots 0..4 serve channels A..E and the
//   remaining slots are no-ops. Key events from the register block are held
//   per channel as a 2-bit pending code. Each code is presented as a one-slot
//   ch_key_* pulse in the same cycle as that channel's `active` index.
//
// Ports
//   clk              system clock, all state on rising edge
//   reset            asynchronous, active-high; clears all state
//   enable           1 = sequencing advances, 0 = hold slot, outputs forced to 0
//   key_on_req       per-channel key-on request pulses (bit n = channel n)
//   key_release_req  per-channel release request pulses
//   key_off_req      per-channel immediate-off request pulses
//   active           registered slot index: 1..5 = channel A..E, 0 = no-op
//   ch_key_on        registered, valid with active
//   ch_key_release   registered, valid with active
//   ch_key_off       registered, valid with active
//   frame_start      registered pulse coinciding with active = 1
//   pending          combinational, bit n = channel n has an undelivered event

// Per-channel pending event holder. A new request always wins over the
// delivery clear, so a request arriving in the delivery cycle is kept for
// the next frame while the old code goes out on the outputs.
module wts_channel_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       on_req,
  input  logic       release_req,
  input  logic       off_req,
  input  logic       deliver,
  output logic [1:0] code
);

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] REL  = 2'd2;
  localparam logic [1:0] OFF  = 2'd3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            code <= NONE;
    else if (off_req)     code <= OFF;
    else if (release_req) code <= REL;
    else if (on_req)      code <= ON;
    else if (deliver)     code <= NONE;
  end

endmodule

module wts_channel_scheduler #(
  parameter int PERIOD = 6,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [4:0]    key_on_req,
  input  logic [4:0]    key_release_req,
  input  logic [4:0]    key_off_req,
  output logic [2:0]    active,
  output logic          ch_key_on,
  output logic          ch_key_release,
  output logic          ch_key_off,
  output logic          frame_start,
  output logic [4:0]    pending
);

  localparam int         NUM_CH = 5;
  localparam logic [1:0] NONE   = 2'd0;
  localparam logic [1:0] ON     = 2'd1;
  localparam logic [1:0] REL    = 2'd2;
  localparam logic [1:0] OFF    = 2'd3;

  logic [CW-1:0]            slot;
  logic [NUM_CH-1:0][1:0]   code;
  logic [NUM_CH-1:0]        deliver;
  logic [1:0]               sel_code;
  logic                     slot_is_ch;

  // Slot counter: free-running while enabled, frozen otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            slot <= '0;
    else if (enable) begin
      if (slot == CW'(PERIOD - 1))        slot <= '0;
      else                                slot <= slot + CW'(1);
    end
  end

  // Channel n is delivered on the edge that loads active = n+1.
  always_comb begin
    deliver = '0;
    for (int n = 0; n < NUM_CH; n++)
      deliver[n] = enable && (slot == CW'(n));
  end

  wts_channel_slot u_ch [NUM_CH-1:0] (
    .clk         (clk),
    .reset       (reset),
    .on_req      (key_on_req),
    .release_req (key_release_req),
    .off_req     (key_off_req),
    .deliver     (deliver),
    .code        (code)
  );

  // Code of the channel owning the current slot; NONE on no-op slots.
  always_comb begin
    slot_is_ch = (slot < CW'(NUM_CH));
    sel_code   = NONE;
    for (int n = 0; n < NUM_CH; n++)
      if (slot == CW'(n)) sel_code = code[n];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active         <= 3'd0;
      frame_start    <= 1'b0;
      ch_key_on      <= 1'b0;
      ch_key_release <= 1'b0;
      ch_key_off     <= 1'b0;
    end else if (enable) begin
      active         <= slot_is_ch ? (slot[2:0] + 3'd1) : 3'd0;
      frame_start    <= (slot == '0);
      ch_key_on      <= (sel_code == ON);
      ch_key_release <= (sel_code == REL);
      ch_key_off     <= (sel_code == OFF);
    end else begin
      active         <= 3'd0;
      frame_start    <= 1'b0;
      ch_key_on      <= 1'b0;
      ch_key_release <= 1'b0;
      ch_key_off     <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    for (int n = 0; n < NUM_CH; n++)
      pending[n] = (code[n] != NONE);
  end

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Bench for wts_channel_scheduler: a PERIOD=6 and a PERIOD=8 instance share
// stimulus; each is compared every cycle with an event-level reference model.
module tb_wts_channel_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] kon = '0, krel = '0, koff = '0;

  logic [2:0] act [2];
  logic       on [2], rel [2], off [2], fs [2];
  logic [4:0] pend [2];

  always #5 clk = ~clk;

  wts_channel_scheduler #(.PERIOD(6), .CW(6)) u6 (
    .clk(clk), .reset(reset), .enable(enable),
    .key_on_req(kon), .key_release_req(krel), .key_off_req(koff),
    .active(act[0]), .ch_key_on(on[0]), .ch_key_release(rel[0]),
    .ch_key_off(off[0]), .frame_start(fs[0]), .pending(pend[0])
  );

  wts_channel_scheduler #(.PERIOD(8), .CW(6)) u8 (
    .clk(clk), .reset(reset), .enable(enable),
    .key_on_req(kon), .key_release_req(krel), .key_off_req(koff),
    .active(act[1]), .ch_key_on(on[1]), .ch_key_release(rel[1]),
    .ch_key_off(off[1]), .frame_start(fs[1]), .pending(pend[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: position in the frame, latest undelivered event per
  // channel (0 none, 1 on, 2 release, 3 off) and the expected outputs.
  int per [2] = '{6, 8};
  int ms [2];
  int mev [2][5];
  int ea [2], ef [2], ek [2];

  // Output bundle {on, release, off} for an event.
  function automatic int key_of(input int ev);
    case (ev)
      1: return 4;
      2: return 2;
      3: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      ms[d] = 0; ea[d] = 0; ef[d] = 0; ek[d] = 0;
      for (int n = 0; n < 5; n++) mev[d][n] = 0;
    end
  endfunction

  function automatic void m_step();
    for (int d = 0; d < 2; d++) begin
      int s;
      s = ms[d];
      if (enable) begin
        ea[d] = (s < 5) ? s + 1 : 0;
        ef[d] = (s == 0) ? 1 : 0;
        ek[d] = (s < 5) ? key_of(mev[d][s]) : 0;
      end else begin
        ea[d] = 0; ef[d] = 0; ek[d] = 0;
      end
      for (int n = 0; n < 5; n++) begin
        int r;
        r = koff[n] ? 3 : krel[n] ? 2 : kon[n] ? 1 : 0;
        if (r != 0)                    mev[d][n] = r;   // latest request wins
        else if (enable && s == n)     mev[d][n] = 0;   // delivered this edge
      end
      if (enable) ms[d] = (s + 1) % per[d];
    end
  endfunction

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [4:0] ep;
      ep = '0;
      for (int n = 0; n < 5; n++) ep[n] = (mev[d][n] != 0);
      chk($sformatf("active_p%0d", per[d]), act[d], ea[d]);
      chk($sformatf("frame_start_p%0d", per[d]), fs[d], ef[d]);
      chk($sformatf("keys_p%0d", per[d]), {on[d], rel[d], off[d]}, ek[d]);
      chk($sformatf("pending_p%0d", per[d]), pend[d], ep);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) m_reset();
    else       m_step();
    #1;
    compare_all();
  endtask

  // Advance until the PERIOD=6 instance shows active = v.
  task automatic wait_act(input int v);
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ea[0] == v) found = 1;
      else cyc();
    end
    if (!found) chk($sformatf("wait_active_%0d", v), 0, 1);
  endtask

  // Asynchronous reset pulse starting just after an edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_reset();
    compare_all();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk("reset_active", act[0], 0);
    chk("reset_pending", pend[0], 0);
    cyc();
    reset = 1'b0;
    enable = 1'b1;
    repeat (14) cyc();

    // key-on for channel C issued while active = 1
    wait_act(1);
    kon = 5'b00100; cyc(); kon = '0;
    chk("on_c_pending", pend[0][2], 1);
    wait_act(3);
    chk("on_c_delivered", {on[0], rel[0], off[0]}, 4);
    chk("on_c_cleared", pend[0][2], 0);

    // simultaneous on + off for channel A: off wins
    wait_act(5);
    kon = 5'b00001; koff = 5'b00001; cyc(); kon = '0; koff = '0;
    wait_act(1);
    chk("off_beats_on", {on[0], rel[0], off[0]}, 1);

    // release then on for channel B: latest wins
    wait_act(5);
    krel = 5'b00010; cyc(); krel = '0;
    kon  = 5'b00010; cyc(); kon  = '0;
    wait_act(2);
    chk("latest_wins", {on[0], rel[0], off[0]}, 4);

    // channel E: on arrives in its delivery cycle with release pending
    wait_act(1);
    krel = 5'b10000; cyc(); krel = '0;
    wait_act(4);
    kon = 5'b10000; cyc(); kon = '0;
    chk("e_release_first", {on[0], rel[0], off[0]}, 2);
    repeat (6) cyc();
    chk("e_on_next_frame", {act[0], on[0]}, {3'd5, 1'b1});

    // enable dropped at active = 3 for 4 cycles
    wait_act(3);
    enable = 1'b0;
    repeat (4) begin cyc(); chk("disabled_active", act[0], 0); end
    enable = 1'b1;
    cyc();
    chk("resume_active", act[0], 4);

    // reset while channel A has a pending event
    kon = 5'b00001; cyc(); kon = '0;
    chk("a_pending", pend[0][0], 1);
    do_reset();
    chk("a_discarded", pend[0], 0);
    repeat (16) cyc();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      kon  = 5'($urandom & $urandom & $urandom);
      krel = 5'($urandom & $urandom & $urandom);
      koff = 5'($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      else                             cyc();
    end
    kon = '0; krel = '0; koff = '0; enable = 1'b1;
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
